// File: rtl/btn_chord_conditioner_pkg.sv
// btn_chord_conditioner_pkg: shared width and FSM state type for the button chord conditioner
package btn_cond_pkg;
  localparam int BTN_W = 4;
  typedef enum logic [1:0] {IDLE, ARMED, EMIT, STUCK} btn_cond_state_t;
endpackage

// File: rtl/btn_chord_conditioner_if.sv
// btn_chord_conditioner_if: raw button levels in, chord event and status out
interface btn_chord_conditioner_if;
  import btn_cond_pkg::*;
  logic [BTN_W-1:0] btn_raw;
  logic [BTN_W-1:0] btn;
  logic busy;
  logic stuck;
  modport master (output btn_raw, input btn, busy, stuck);
  modport slave (input btn_raw, output btn, busy, stuck);
endinterface

// File: rtl/btn_chord_conditioner_debounce.sv
// btn_debounce: accepts the whole vector once it has been stable for DEBOUNCE_CYCLES samples
module btn_debounce #(
  parameter int W = 4,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [W-1:0] cand;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk)
    if (rst) begin
      cand <= '0;
      cnt <= '0;
      dout <= '0;
    end else if (din != cand) begin
      cand <= din;
      cnt <= '0;
    end else if (cnt == LAST) dout <= cand;
    else cnt <= cnt + 1'b1;
endmodule

// File: rtl/btn_chord_conditioner.sv
// btn_chord_conditioner: sync + debounce four buttons and emit one OR-ed chord code per gesture
module btn_chord_conditioner
  import btn_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int HOLD_MAX_CYCLES = 250_000_000
) (
  input logic clk,
  input logic rst,
  btn_chord_conditioner_if.slave bus
);
  localparam int HW = $clog2(HOLD_MAX_CYCLES + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MAX_CYCLES - 1);
  logic [BTN_W-1:0] s1, s2, deb, acc;
  logic [HW-1:0] hold;
  btn_cond_state_t state, state_nx;
  always_ff @(posedge clk)
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= bus.btn_raw;
      s2 <= s1;
    end
  btn_debounce #(.W(BTN_W), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
    .clk(clk),
    .rst(rst),
    .din(s2),
    .dout(deb)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  // a release always wins over the hold timeout
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = (deb != '0) ? ARMED : IDLE;
      ARMED: state_nx = (deb == '0) ? EMIT : (hold == HOLD_LAST) ? STUCK : ARMED;
      EMIT:  state_nx = IDLE;
      STUCK: state_nx = (deb == '0) ? IDLE : STUCK;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      acc <= '0;
      hold <= '0;
    end else
      case (state)
        IDLE:
          if (deb != '0) begin
            acc <= deb;
            hold <= '0;
          end
        ARMED: begin
          acc <= acc | deb;
          hold <= hold + 1'b1;
        end
        default: acc <= '0;
      endcase
  always_comb begin
    bus.btn = (state == EMIT) ? acc : '0;
    bus.busy = (state == ARMED) || (state == STUCK);
    bus.stuck = (state == STUCK);
  end
endmodule

// File: tb/tb_btn_chord_conditioner.sv
// tb_btn_chord_conditioner: directed test-plan gestures plus random presses against a gesture-level model
module tb_btn_chord_conditioner;
  localparam int D = 4;
  localparam int H = 32;
  logic clk = 1'b0;
  logic rst;
  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  btn_chord_conditioner_if bus ();
  btn_chord_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_MAX_CYCLES(H)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  typedef struct {
    logic [3:0] s1, s2, run_val, deb, chord;
    int run_len, held;
    bit active, timed_out, emitting;
  } mdl_t;
  mdl_t m;
  function automatic mdl_t model_next(mdl_t c, logic [3:0] raw, logic r);
    mdl_t n = c;
    if (r) begin
      n = '{default: 0};
      n.run_len = 1;
      return n;
    end
    n.s1 = raw;
    n.s2 = c.s1;
    if (c.s2 == c.run_val) n.run_len = c.run_len + 1;
    else begin
      n.run_val = c.s2;
      n.run_len = 1;
    end
    if (n.run_len >= D + 1) n.deb = n.run_val;
    if (c.emitting) begin
      n.emitting = 0;
      n.active = 0;
      n.chord = 0;
    end else if (!c.active) begin
      if (c.deb != 0) begin
        n.active = 1;
        n.chord = c.deb;
        n.held = 0;
      end
    end else if (c.timed_out) begin
      if (c.deb == 0) begin
        n.active = 0;
        n.timed_out = 0;
        n.chord = 0;
      end
    end else begin
      n.chord = c.chord | c.deb;
      n.held = c.held + 1;
      if (c.deb == 0) n.emitting = 1;
      else if (n.held == H) n.timed_out = 1;
    end
    return n;
  endfunction
  always @(posedge clk) m <= model_next(m, bus.btn_raw, rst);
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  int ev_cnt, ev_cyc, busy_rise, stuck_rise;
  logic [3:0] ev_code, prev_btn;
  bit adj, busy_seen, stuck_seen;
  logic prev_busy, prev_stuck;
  always @(negedge clk) begin
    chk("btn", 32'(bus.btn), 32'(m.emitting ? m.chord : 4'h0));
    chk("busy", 32'(bus.busy), 32'(m.active && !m.emitting));
    chk("stuck", 32'(bus.stuck), 32'(m.timed_out));
    if (bus.btn != 0) begin
      ev_cnt++;
      ev_code = bus.btn;
      ev_cyc = cyc;
      if (prev_btn != 0) adj = 1;
    end
    if (bus.busy && !prev_busy) busy_rise = cyc;
    if (bus.stuck && !prev_stuck) stuck_rise = cyc;
    busy_seen |= bus.busy;
    stuck_seen |= bus.stuck;
    prev_btn = bus.btn;
    prev_busy = bus.busy;
    prev_stuck = bus.stuck;
  end
  task automatic clr();
    ev_cnt = 0;
    ev_code = 0;
    ev_cyc = 0;
    adj = 0;
    busy_seen = 0;
    stuck_seen = 0;
    busy_rise = 0;
    stuck_rise = 0;
  endtask
  int rel;
  task automatic step(logic [3:0] v, int n);
    bus.btn_raw = v;
    rel = cyc + 1;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk_zero(string tag);
    chk({tag, "_btn"}, 32'(bus.btn), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_stuck"}, 32'(bus.stuck), 0);
  endtask
  initial begin
    int rel_single;
    bus.btn_raw = 4'h0;
    rst = 1'b1;
    prev_btn = 0;
    prev_busy = 0;
    prev_stuck = 0;
    clr();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    step(4'h0, 10);
    clr();
    step(4'h7, 20);
    step(4'h0, 12);
    rel_single = rel;
    chk("single_cnt", ev_cnt, 1);
    chk("single_code", 32'(ev_code), 32'h7);
    chk("single_lat", ev_cyc - rel_single, 7);
    chk("single_busy", 32'(busy_seen), 1);
    clr();
    step(4'h1, 3);
    step(4'h0, 12);
    chk("glitch_cnt", ev_cnt, 0);
    chk("glitch_busy", 32'(busy_seen), 0);
    clr();
    step(4'h4, 10);
    step(4'h6, 8);
    step(4'h2, 8);
    step(4'h0, 12);
    chk("chord_cnt", ev_cnt, 1);
    chk("chord_code", 32'(ev_code), 32'h6);
    clr();
    step(4'hd, 60);
    chk("timeout_stuck_hi", 32'(bus.stuck), 1);
    step(4'h0, 12);
    chk("timeout_cnt", ev_cnt, 0);
    chk("timeout_seen", 32'(stuck_seen), 1);
    chk("timeout_delay", stuck_rise - busy_rise, H);
    chk("timeout_stuck_lo", 32'(bus.stuck), 0);
    clr();
    step(4'h8, 10);
    chk("mid_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    step(4'h8, 1);
    chk_zero("mid_rst");
    rst = 1'b0;
    step(4'h8, 1);
    chk_zero("mid_after");
    step(4'h8, 10);
    step(4'h0, 12);
    chk("mid_cnt", ev_cnt, 1);
    chk("mid_code", 32'(ev_code), 32'h8);
    clr();
    step(4'hd, 6);
    step(4'h0, 6);
    step(4'hd, 6);
    step(4'h0, 12);
    chk("b2b_cnt", ev_cnt, 2);
    chk("b2b_code", 32'(ev_code), 32'hd);
    chk("b2b_adj", 32'(adj), 0);
    for (int i = 0; i < 150; i++) begin
      logic [3:0] v;
      int n;
      v = 4'($urandom_range(0, 15));
      n = ($urandom_range(0, 9) == 0) ? int'($urandom_range(30, 45)) : int'($urandom_range(1, 8));
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        step(v, 1);
        rst = 1'b0;
      end
      step(v, n);
    end
    step(4'h0, 12);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/btn_chord_conditioner.md
# btn_chord_conditioner

Upstream input stage for the safe-lock FSM. It takes the four raw, asynchronous push-button levels and synchronizes and debounces them. It then collects every button pressed during one press-and-release gesture into a "chord" and presents that chord as a single-cycle 4-bit code on `btn`. The lock FSM consumes `btn` directly: it is all-zero except for exactly one cycle per completed gesture.

## Interface
- `DEBOUNCE_CYCLES`, default 500_000: consecutive identical synchronized samples required before a level is accepted (10 ms at 50 MHz); legal range ≥ 1.
- `HOLD_MAX_CYCLES`, default 250_000_000: maximum cycles a chord may stay held before it is discarded (5 s at 50 MHz); legal range ≥ 1.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_raw`  in  4  raw button levels, asynchronous, 1 = pressed.
- `btn`  out  4  chord event code; non-zero for exactly one cycle per accepted gesture.
- `busy`  out  1  high while a gesture is in progress (ARMED or STUCK).
- `stuck`  out  1  high while in STUCK (hold timeout, waiting for release).

## Operation
- **Synchronizer:** 2-flop chain per bit, `btn_raw` → `s1` → `s2`.
- **Debouncer:**
  - Holds a candidate vector `cand` and a counter `cnt` of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - If `s2 != cand`: `cand <= s2`, `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `deb <= cand`; `cnt` saturates at that value.
  - Else: `cnt <= cnt+1`.
  - The whole vector is debounced as one unit.
- **FSM** (states IDLE, ARMED, EMIT, STUCK):
  - IDLE: if `deb != 0` → ARMED, `acc <= deb`, `hold <= 0`.
  - ARMED: `acc <= acc | deb`, `hold <= hold+1`.
    - If `deb == 0` → EMIT.
    - Else if `hold == HOLD_MAX_CYCLES-1` → STUCK.
    - The release check has priority over the timeout.
  - EMIT: → IDLE unconditionally; `acc` is cleared on exit.
  - STUCK: stays until `deb == 0`, then → IDLE. No event is emitted; `acc` is cleared.
- **Outputs:**
  - `btn = (state == EMIT) ? acc : 4'b0`.
  - `busy = (state == ARMED || state == STUCK)`.
  - `stuck = (state == STUCK)`.
  - All outputs are decoded from registers only; there is no combinational path from `btn_raw`.
- **Chord semantics:** the event code is the OR of every debounced level seen between the first press and the full release. Example: press 0100, add 0010, release 0100 first, then 0010 → event 0110.
- **Reset:**
  - Clears `s1`, `s2`, `cand`, `deb`, `cnt`, `acc`, `hold`; state → IDLE.
  - Reset values: `btn = 0`, `busy = 0`, `stuck = 0`.
  - Reset in the middle of a gesture discards it; no event follows.
  - Buttons still held when reset releases are debounced afresh and start a new gesture.

## Timing
- **Press latency:** a raw level held constant from edge k is visible on `deb` at edge k+2+DEBOUNCE_CYCLES.
  - Any raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronized samples never reaches `deb`.
- **Event latency:** `deb` goes 0 at edge r → EMIT at edge r+1 → `btn` non-zero for cycle r+1 only, 0 from r+2.
- **Minimum gap:** one IDLE cycle separates consecutive events, so two events can never be adjacent.
- **Timeout:** ARMED entered at edge a; STUCK at edge a+HOLD_MAX_CYCLES if `deb` stayed non-zero throughout.
- **Wrap-around:** `hold` and `cnt` never wrap; they are reset or saturated as above.

## Structure
- **Package `btn_cond_pkg`:**
  - `BTN_W = 4`.
  - State enum `btn_cond_state_t` (IDLE, ARMED, EMIT, STUCK), binary encoded.
- **Sub-module `btn_debounce`:** parameters `W` and `DEBOUNCE_CYCLES`; ports `clk`, `rst`, `din[W-1:0]` (already synchronized), `dout[W-1:0]`.
- **Top:** the top holds the synchronizer, the FSM, `acc`, and the `hold` counter.

## Test plan
Use DEBOUNCE_CYCLES = 4 and HOLD_MAX_CYCLES = 32 on the bench.
- **Single press:** `btn_raw = 0111` for 20 cycles, then 0000 → exactly one cycle of `btn = 0111`, 7 cycles after the raw release edge (2 sync + 4 debounce + 1). `busy` is high from `deb` rise until EMIT.
- **Glitch rejection:** `btn_raw = 0001` for 3 cycles, then 0000 → `deb` and `btn` stay 0 and `busy` never rises.
- **Chord accumulation:** press 0100, add 0010 after 10 cycles, release 0100, then 0010 (each change held ≥ 6 cycles) → a single event `btn = 0110`.
- **Hold timeout:** hold 1101 for 60 cycles, then release → `stuck` rises 32 cycles after ARMED and falls on `deb == 0`; `btn` stays 0 throughout.
- **Reset mid-gesture:** assert `rst` for 1 cycle while ARMED with `acc = 1000`, raw still 1000, then release after 10 cycles → no event from the old gesture. The new gesture yields one event `btn = 1000`, and all outputs are 0 during and just after reset.
- **Back-to-back gestures:** two 1101 press/release gestures, each phase held 6 cycles → two events `btn = 1101`, separated by at least one zero cycle.
